// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU control / M-extension block: ALU function codes,
// ALUOp encodings, branch and M-op funct3 values, FSM state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1010;
  localparam logic [3:0] ALU_BGEU = 4'b1011;
  localparam logic [3:0] ALU_JMP  = 4'b1111;

  localparam logic [1:0] ALUOP_JMP    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_LDST   = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // Returns {illegal, alu_code}; funct3 010/011 are not branches.
  function automatic logic [4:0] branch_decode(input logic [2:0] f3);
    case (f3)
      F3_BEQ:  return {1'b0, ALU_XOR};
      F3_BNE:  return {1'b0, ALU_BNE};
      F3_BLT:  return {1'b0, ALU_SLT};
      F3_BGE:  return {1'b0, ALU_BGE};
      F3_BLTU: return {1'b0, ALU_SLTU};
      F3_BGEU: return {1'b0, ALU_BGEU};
      default: return {1'b1, ALU_XOR};
    endcase
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per step on magnitudes.
// Divider datapath exists only when RVM_DIV_EN is defined.
module md_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [1:0]      f3_lo,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            spec_hit,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] acc_q, acc_nxt, prod_fix;
  logic [XLEN-1:0]   b_q, a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic              a_neg, b_neg, neg_q, hi_q;

`ifdef RVM_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic              div_q, rem_q, rneg_q, spec_q;
  logic [XLEN-1:0]   spec_val, spec_val_q, div_diff, quo_fix, rem_fix;
  logic [XLEN:0]     div_trial;
`endif

  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    if (is_div) begin
      a_neg = ~f3_lo[0] & rs1[XLEN-1];
      b_neg = ~f3_lo[0] & rs2[XLEN-1];
    end else begin
      a_neg = ~(f3_lo[1] & f3_lo[0]) & rs1[XLEN-1];
      b_neg = ~f3_lo[1] & rs2[XLEN-1];
    end
    a_mag = a_neg ? -rs1 : rs1;
    b_mag = b_neg ? -rs2 : rs2;
  end

  // acc holds {partial_hi, multiplier} for mul and {remainder, quotient} for div
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
`ifdef RVM_DIV_EN
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial[XLEN-1:0] - b_q;
    if (div_q) begin
      if (div_trial >= {1'b0, b_q})
        acc_nxt = {div_diff, acc_q[XLEN-2:0], 1'b1};
      else
        acc_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
      hi_q  <= 1'b0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
      b_q   <= is_div ? b_mag : a_mag;
      neg_q <= a_neg ^ b_neg;
      hi_q  <= |f3_lo;
    end else if (step) begin
      acc_q <= acc_nxt;
    end
  end

`ifdef RVM_DIV_EN
  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
    if (is_div && rs2 == '0) begin
      spec_hit = 1'b1;
      spec_val = f3_lo[1] ? rs1 : '1;
    end else if (is_div && !f3_lo[0] && rs1 == MOST_NEG && rs2 == '1) begin
      spec_hit = 1'b1;
      spec_val = f3_lo[1] ? '0 : rs1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= 1'b0;
      rem_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else if (load) begin
      div_q      <= is_div;
      rem_q      <= f3_lo[1];
      rneg_q     <= a_neg;
      spec_q     <= spec_hit;
      spec_val_q <= spec_val;
    end
  end
`else
  assign spec_hit = 1'b0;
`endif

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    result   = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
`ifdef RVM_DIV_EN
    quo_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (spec_q)
      result = spec_val_q;
    else if (div_q)
      result = rem_q ? rem_fix : quo_fix;
`endif
  end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decode with iterative M-extension mul/div behind a valid/ready handshake.
// Define RVM_DIV_EN to build the divider; otherwise DIV-class ops complete as illegal.
//
// state  | meaning
// S_IDLE | ready for a request
// S_MUL  | multiplier stepping, counter running down
// S_DIV  | divider stepping, counter running down
// S_DONE | result held until out_ready
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit EARLY_DONE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic            md_sel,
  output logic [XLEN-1:0] md_result,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN) + 1;
`ifdef RVM_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        dec_code;
  logic [4:0]        br;
  logic              dec_illegal, dec_m, accept, iterating, spec_hit;
  logic [XLEN-1:0]   iter_result;

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign iterating = (state_q == S_MUL) || (state_q == S_DIV);

  always_comb begin
    dec_code    = ALU_ADD;
    dec_illegal = 1'b0;
    dec_m       = 1'b0;
    br          = branch_decode(funct3);
    case (alu_op)
      ALUOP_JMP:    dec_code = ALU_JMP;
      ALUOP_BRANCH: {dec_illegal, dec_code} = br;
      ALUOP_ARITH: begin
        if (funct7 == F7_MEXT) begin
          dec_m       = 1'b1;
          dec_illegal = funct3[2] && !DIV_EN;
        end else begin
          dec_code = {funct7[5], funct3};
        end
      end
      default:      dec_code = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!dec_m)
            state_d = S_DONE;
          else if (!funct3[2])
            state_d = S_MUL;
          else if (!DIV_EN || (EARLY_DONE && spec_hit))
            state_d = S_DONE;
          else
            state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:       if (out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // down-counter: loaded with XLEN on accept, parks at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (flush)
      cnt_q <= '0;
    else if (accept && (state_d == S_MUL || state_d == S_DIV))
      cnt_q <= CNT_W'(XLEN);
    else if (iterating && cnt_q != '0)
      cnt_q <= cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control <= 4'b0000;
      md_sel      <= 1'b0;
      illegal     <= 1'b0;
    end else if (accept) begin
      alu_control <= dec_code;
      md_sel      <= dec_m;
      illegal     <= dec_illegal;
    end
  end

  md_iter #(.XLEN(XLEN)) u_md_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && dec_m),
    .step     (iterating && !flush),
    .is_div   (funct3[2]),
    .f3_lo    (funct3[1:0]),
    .rs1      (rs1),
    .rs2      (rs2),
    .spec_hit (spec_hit),
    .result   (iter_result)
  );

  assign md_result = (md_sel && !illegal) ? iter_result : '0;

endmodule

// File: tb/tb_alu_control_md.sv
// Randomized bench for alu_control_md against an arithmetic reference model.
module tb_alu_control_md;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [6:0]  funct7 = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] rs1 = 32'b0;
  logic [31:0] rs2 = 32'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_control;
  logic        md_sel;
  logic [31:0] md_result;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  code;
    logic        md_sel;
    logic        ill;
    logic [31:0] res;
    logic [7:0]  lat;
  } exp_t;

  alu_control_md #(.XLEN(32), .EARLY_DONE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .md_sel(md_sel),
    .md_result(md_result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [3:0]  btab [8];
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] q, r;
    bit          special;
    btab = '{4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b0010, 4'b1010, 4'b0011, 4'b1011};
    e = '0;
    e.lat = 8'd1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p = 64'h0;
    q = 32'h0;
    r = 32'h0;
    special = 1'b0;
    case (op)
      ALUOP_JMP:    e.code = ALU_JMP;
      ALUOP_LDST:   e.code = ALU_ADD;
      ALUOP_BRANCH: begin
        e.code = btab[f3];
        e.ill  = (f3 == 3'd2) || (f3 == 3'd3);
      end
      default: begin
        if (f7 == 7'h01) begin
          e.md_sel = 1'b1;
          if (!f3[2]) begin
            case (f3[1:0])
              2'd0, 2'd1: p = sa * sb;
              2'd2:       p = sa * ub;
              default:    p = ua * ub;
            endcase
            e.res = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
            e.lat = 8'd33;
          end else begin
`ifdef RVM_DIV_EN
            if (b == 32'h0) begin
              q = 32'hFFFF_FFFF; r = a; special = 1'b1;
            end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              q = a; r = 32'h0; special = 1'b1;
            end else if (!f3[0]) begin
              q = 32'(sa / sb); r = 32'(sa % sb);
            end else begin
              q = a / b; r = a % b;
            end
            e.res = f3[1] ? r : q;
            e.lat = special ? 8'd1 : 8'd33;
`else
            e.ill = 1'b1;
            e.res = 32'h0;
`endif
          end
        end else begin
          e.code = {f7[5], f3};
        end
      end
    endcase
    return e;
  endfunction

  task automatic send_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk_eq({tag, " ready"}, 64'(in_ready), 64'd1);
    alu_op = op; funct7 = f7; funct3 = f3; rs1 = a; rs2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input int hold,
                        input string tag);
    exp_t e;
    int   k;
    bit   seen;
    e = model(op, f7, f3, a, b);
    send_op(op, f7, f3, a, b, tag);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      seen = out_valid;
    end
    chk_eq({tag, " latency"}, seen ? 64'(k) : 64'hFFFF, 64'(e.lat));
    chk_eq({tag, " flags"}, {62'h0, md_sel, illegal}, {62'h0, e.md_sel, e.ill});
    chk_eq({tag, " md_result"}, 64'(md_result), 64'(e.res));
    if (!e.md_sel) chk_eq({tag, " alu_control"}, 64'(alu_control), 64'(e.code));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_eq({tag, " hold"}, {in_ready, out_valid, md_result, alu_control},
             {1'b0, 1'b1, e.res, e.code});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk_eq({tag, " release"}, {62'h0, in_ready, out_valid}, 64'b10);
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    chk_eq({tag, " rst_outs"}, {in_ready, out_valid, alu_control, md_sel, illegal, md_result}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq({tag, " rst_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin : main
    logic [1:0]  r_op;
    logic [6:0]  r_f7;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_b;
    bit          seen;

    #2;
    chk_eq("reset", {in_ready, out_valid, alu_control, md_sel, illegal, md_result}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("post_reset_ready", 64'(in_ready), 64'd1);

    run_op(ALUOP_ARITH, 7'b0100000, 3'b000, 32'd9, 32'd4, 0, "sub");
    run_op(ALUOP_ARITH, 7'h01, F3_MULH, 32'hFFFF_FFFF, 32'd3, 0, "mulh");
    run_op(ALUOP_ARITH, 7'h01, F3_MUL, 32'hFFFF_FFFF, 32'd3, 0, "mul");
    run_op(ALUOP_ARITH, 7'h01, F3_DIVU, 32'd7, 32'd0, 0, "divu0");
    run_op(ALUOP_ARITH, 7'h01, F3_REMU, 32'd7, 32'd0, 0, "remu0");
    run_op(ALUOP_ARITH, 7'h01, F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(ALUOP_ARITH, 7'h01, F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(ALUOP_ARITH, 7'h01, F3_DIV, 32'd10, 32'd2, 0, "div10_2");
    run_op(ALUOP_BRANCH, 7'h00, 3'b011, 32'd0, 32'd0, 0, "br_bad");
    run_op(ALUOP_JMP, 7'h00, 3'b000, 32'd0, 32'd0, 0, "jmp");
    run_op(ALUOP_ARITH, 7'b0100000, 3'b000, 32'd1, 32'd1, 5, "sub_hold");

    // flush ten cycles into a multiply
    send_op(ALUOP_ARITH, 7'h01, F3_MUL, 32'd1234, 32'd5678, "flush");
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk_eq("flush_idle", {62'h0, in_ready, out_valid}, 64'b10);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk_eq("flush_no_valid", 64'(seen), 64'd0);

    send_op(ALUOP_ARITH, 7'h01, F3_DIV, 32'd100, 32'd7, "rst_div");
    repeat (5) @(negedge clk);
    reset_now("rst_div");
    send_op(ALUOP_ARITH, 7'b0100000, 3'b000, 32'd3, 32'd1, "rst_done");
    repeat (2) @(negedge clk);
    reset_now("rst_done");

    for (int n = 0; n < 60; n++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       r_f7 = 7'h00;
        1:       r_f7 = 7'h20;
        2:       r_f7 = 7'h01;
        default: r_f7 = 7'($urandom);
      endcase
      if (n % 3 == 0) begin
        r_op = ALUOP_ARITH;
        r_f7 = 7'h01;
      end
      r_f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       r_a = 32'h0;
        1:       r_a = 32'hFFFF_FFFF;
        2:       r_a = 32'h8000_0000;
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       r_b = 32'h0;
        1:       r_b = 32'hFFFF_FFFF;
        2:       r_b = 32'd3;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_f7, r_f3, r_a, r_b, 0, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
